// File: rtl/noc_tg_pkg.sv
// rtl/noc_tg_pkg.sv - shared types and payload helpers for the NoC traffic generator/checker pair
package noc_tg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tg_state_t;

    // Self-describing 32-bit beat pattern; callers pass 8-bit fields.
    function automatic logic [31:0] tg_word(
        input logic [7:0] src,
        input logic [7:0] dest,
        input logic [7:0] seq,
        input logic [7:0] beat
    );
        return {src, dest, seq, beat};
    endfunction

    // Next destination around the ring, skipping the source endpoint.
    // A single-endpoint ring loops back to the source.
    function automatic int tg_next_dest(input int dest, input int src, input int n);
        int nx;
        if (n <= 1) begin
            return src;
        end
        nx = dest + 1;
        if (nx >= n) begin
            nx = 0;
        end
        if (nx == src) begin
            nx = nx + 1;
            if (nx >= n) begin
                nx = 0;
            end
        end
        return nx;
    endfunction

endpackage

// File: rtl/axis_traffic_gen.sv
// rtl/axis_traffic_gen.sv - AXI-Stream packet generator with ring destination rotation and statistics
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : run start pulse, honoured in IDLE or DONE only
//   axis_t*           : AXI-Stream master (registered outputs)
//   busy, done        : run status
//   beats_sent        : accepted beats this run (wrapping)
//   stall_cycles      : tvalid & !tready cycles this run (saturating)
module axis_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int NUM_ROUTERS = 4,
    parameter int SRC_ID      = 0,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int PACKET_LEN  = 4,
    parameter int NUM_PACKETS = 16,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic                   axis_tlast,
    output logic [TID_WIDTH-1:0]   axis_tid,
    output logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            beats_sent,
    output logic [31:0]            stall_cycles
);

    localparam int BEAT_W     = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int SEQ_W      = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
    localparam int GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int NUM_WORDS  = TDATA_WIDTH / 32;
    localparam int FIRST_DEST = tg_next_dest(SRC_ID, SRC_ID, NUM_ROUTERS);

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(PACKET_LEN - 1);
    localparam logic [SEQ_W-1:0]  LAST_SEQ    = SEQ_W'(NUM_PACKETS - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic              FIRST_TLAST = (PACKET_LEN == 1);

    tg_state_t              state;
    logic [BEAT_W-1:0]      beat;
    logic [BEAT_W-1:0]      beat_nx;
    logic [SEQ_W-1:0]       seq;
    logic [SEQ_W-1:0]       seq_nx;
    logic [TDEST_WIDTH-1:0] dest;
    logic [TDEST_WIDTH-1:0] dest_nx;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   last_beat;
    logic                   last_pkt;
    logic [31:0]            word_nx;
    logic [31:0]            word_first;

    // Position of the beat that follows an acceptance; the output registers
    // are loaded from these so the bus always shows the current beat.
    always_comb begin
        last_beat  = (beat == LAST_BEAT);
        last_pkt   = (seq == LAST_SEQ);
        beat_nx    = last_beat ? '0 : beat + 1'b1;
        seq_nx     = last_beat ? seq + 1'b1 : seq;
        dest_nx    = last_beat ? TDEST_WIDTH'(tg_next_dest(int'(dest), SRC_ID, NUM_ROUTERS)) : dest;
        word_nx    = tg_word(8'(SRC_ID), 8'(dest_nx), 8'(seq_nx), 8'(beat_nx));
        word_first = tg_word(8'(SRC_ID), 8'(FIRST_DEST), 8'd0, 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            seq          <= '0;
            dest         <= '0;
            gap_cnt      <= '0;
            axis_tvalid  <= 1'b0;
            axis_tlast   <= 1'b0;
            axis_tdata   <= '0;
            axis_tid     <= '0;
            axis_tdest   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            beats_sent   <= '0;
            stall_cycles <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= SEND;
                        beat         <= '0;
                        seq          <= '0;
                        dest         <= TDEST_WIDTH'(FIRST_DEST);
                        beats_sent   <= '0;
                        stall_cycles <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        axis_tvalid  <= 1'b1;
                        axis_tdata   <= {NUM_WORDS{word_first}};
                        axis_tlast   <= FIRST_TLAST;
                        axis_tid     <= '0;
                        axis_tdest   <= TDEST_WIDTH'(FIRST_DEST);
                    end
                end

                SEND: begin
                    if (!axis_tready) begin
                        if (axis_tvalid && stall_cycles != '1) begin
                            stall_cycles <= stall_cycles + 32'd1;
                        end
                    end else begin
                        beats_sent <= beats_sent + 32'd1;
                        beat       <= beat_nx;
                        seq        <= seq_nx;
                        dest       <= dest_nx;
                        axis_tdata <= {NUM_WORDS{word_nx}};
                        axis_tid   <= TID_WIDTH'(seq_nx);
                        axis_tdest <= dest_nx;
                        axis_tlast <= (beat_nx == LAST_BEAT);
                        if (last_beat) begin
                            if (last_pkt) begin
                                state       <= DONE;
                                axis_tvalid <= 1'b0;
                                axis_tlast  <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                            end else if (GAP_CYCLES > 0) begin
                                // Next packet's fields are already staged; only tvalid drops.
                                state       <= GAP;
                                axis_tvalid <= 1'b0;
                                gap_cnt     <= GAP_LOAD;
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state       <= SEND;
                        axis_tvalid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb/tb_axis_traffic_gen.sv - self-checking bench for axis_traffic_gen
module tb_axis_traffic_gen;

    localparam int N    = 4;
    localparam int SRC  = 1;
    localparam int PL   = 3;
    localparam int NP   = 4;
    localparam int TW   = 512;
    localparam int TIDW = 2;
    localparam int TDW  = 4;
    localparam int NB   = PL * NP;
    localparam int MAXC = 256;
    localparam int RNDC = 200;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic tready;

    logic            tvalid [2];
    logic            tlast  [2];
    logic            busy   [2];
    logic            done   [2];
    logic [TW-1:0]   tdata  [2];
    logic [TIDW-1:0] tid    [2];
    logic [TDW-1:0]  tdest  [2];
    logic [31:0]     beats  [2];
    logic [31:0]     stalls [2];

    always #5 clk = ~clk;

    axis_traffic_gen #(
        .NUM_ROUTERS(N), .SRC_ID(SRC), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW),
        .TDATA_WIDTH(TW), .PACKET_LEN(PL), .NUM_PACKETS(NP), .GAP_CYCLES(0)
    ) u_gen0 (
        .clk(clk), .rst(rst), .start(start),
        .axis_tvalid(tvalid[0]), .axis_tready(tready), .axis_tdata(tdata[0]),
        .axis_tlast(tlast[0]), .axis_tid(tid[0]), .axis_tdest(tdest[0]),
        .busy(busy[0]), .done(done[0]), .beats_sent(beats[0]), .stall_cycles(stalls[0])
    );

    axis_traffic_gen #(
        .NUM_ROUTERS(N), .SRC_ID(SRC), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW),
        .TDATA_WIDTH(TW), .PACKET_LEN(PL), .NUM_PACKETS(NP), .GAP_CYCLES(2)
    ) u_gen2 (
        .clk(clk), .rst(rst), .start(start),
        .axis_tvalid(tvalid[1]), .axis_tready(tready), .axis_tdata(tdata[1]),
        .axis_tlast(tlast[1]), .axis_tid(tid[1]), .axis_tdest(tdest[1]),
        .busy(busy[1]), .done(done[1]), .beats_sent(beats[1]), .stall_cycles(stalls[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    bit rdy     [MAXC];
    int exp_idx [2][MAXC];
    int done_c  [2];
    int exp_stl [2];

    typedef struct {
        int mode;        // 0: tready=1, 1: tready on even cycles, 2: random
        int start_at;    // cycle of an extra start pulse, -1 for none
        int exp_stall0;  // stall count of the gapless generator, -1 = model only
    } vec_t;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ring endpoints other than SRC, in order starting just after SRC.
    function automatic int exp_dest(input int j);
        int p;
        p = j / PL;
        return (SRC + 1 + (p % (N - 1))) % N;
    endfunction

    function automatic logic [TW-1:0] exp_data(input int j);
        logic [31:0] w;
        w = {8'(SRC), 8'(exp_dest(j)), 8'(j / PL), 8'(j % PL)};
        return {(TW / 32){w}};
    endfunction

    // Cycle-level schedule: which beat is presented on each cycle, given tready.
    task automatic build_model(input int g, input int gap);
        int c;
        int s;
        c = 0;
        s = 0;
        for (int k = 0; k < MAXC; k++) exp_idx[g][k] = -1;
        for (int j = 0; j < NB; j++) begin
            while (!rdy[c]) begin
                exp_idx[g][c] = j;
                s++;
                c++;
            end
            exp_idx[g][c] = j;
            c++;
            if ((j % PL) == PL - 1 && j != NB - 1) c += gap;
        end
        done_c[g]  = c;
        exp_stl[g] = s;
    endtask

    task automatic run(input vec_t v);
        int last;
        logic [TW-1:0] pay;
        pay = {(TW / 32){32'h0100_0200}};
        for (int c = 0; c < MAXC; c++) begin
            case (v.mode)
                0:       rdy[c] = 1'b1;
                1:       rdy[c] = (c % 2 == 0);
                default: rdy[c] = (c >= RNDC) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end
        build_model(0, 0);
        build_model(1, 2);
        last = (done_c[0] > done_c[1]) ? done_c[0] : done_c[1];

        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clk);
            start = (c == v.start_at);
            for (int g = 0; g < 2; g++) begin
                int j;
                j = exp_idx[g][c];
                if (c == 0) begin
                    chk($sformatf("g%0d_beats_cleared", g), TW'(beats[g]), '0);
                    chk($sformatf("g%0d_stall_cleared", g), TW'(stalls[g]), '0);
                end
                if (c < done_c[g]) begin
                    chk($sformatf("g%0d_tvalid_c%0d", g, c), TW'(tvalid[g]), TW'(j >= 0));
                    chk($sformatf("g%0d_busy_c%0d", g, c), TW'({busy[g], done[g]}), TW'(2'b10));
                    if (j >= 0) begin
                        chk($sformatf("g%0d_tdata_c%0d", g, c), tdata[g], exp_data(j));
                        chk($sformatf("g%0d_tdest_c%0d", g, c), TW'(tdest[g]), TW'(exp_dest(j)));
                        chk($sformatf("g%0d_tid_c%0d", g, c), TW'(tid[g]), TW'((j / PL) % (1 << TIDW)));
                        chk($sformatf("g%0d_tlast_c%0d", g, c), TW'(tlast[g]), TW'((j % PL) == PL - 1));
                        if (g == 0 && j == 2 * PL) chk("payload_p2b0", tdata[0], pay);
                    end
                end else if (c == done_c[g]) begin
                    chk($sformatf("g%0d_done_flags", g), TW'({busy[g], done[g], tvalid[g]}), TW'(3'b010));
                    chk($sformatf("g%0d_beats_sent", g), TW'(beats[g]), TW'(NB));
                    chk($sformatf("g%0d_stall_cycles", g), TW'(stalls[g]), TW'(exp_stl[g]));
                    if (g == 0 && v.exp_stall0 >= 0)
                        chk("g0_stall_table", TW'(stalls[0]), TW'(v.exp_stall0));
                end else begin
                    chk($sformatf("g%0d_done_hold", g), TW'({done[g], tvalid[g]}), TW'(2'b10));
                end
            end
            tready = rdy[c];
        end
        start = 1'b0;
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{mode: 0, start_at: -1, exp_stall0: 0};
        tbl[1] = '{mode: 1, start_at: -1, exp_stall0: 11};
        tbl[2] = '{mode: 0, start_at: 3,  exp_stall0: 0};
        tbl[3] = '{mode: 2, start_at: -1, exp_stall0: -1};
        tbl[4] = '{mode: 2, start_at: 6,  exp_stall0: -1};

        rst    = 1'b1;
        start  = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_rst_ctrl", g),
                TW'({tvalid[g], tlast[g], busy[g], done[g]}), '0);
            chk($sformatf("g%0d_rst_tdata", g), tdata[g], '0);
            chk($sformatf("g%0d_rst_tid_tdest", g), TW'({tid[g], tdest[g]}), '0);
            chk($sformatf("g%0d_rst_counters", g), TW'({beats[g], stalls[g]}), '0);
        end
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run(tbl[i]);

        // Reset in the middle of the second packet, then replay from scratch.
        @(negedge clk);
        start  = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_tdest_before_rst", TW'({tvalid[0], tdest[0]}), TW'({1'b1, 4'd3}));
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_midrst_ctrl", g), TW'({tvalid[g], busy[g], done[g]}), '0);
            chk($sformatf("g%0d_midrst_counters", g), TW'({beats[g], stalls[g]}), '0);
        end
        rst    = 1'b0;
        tready = 1'b0;
        run(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
